// File: rtl/btb_predictor.sv
// Branch target buffer with per-entry saturating direction counters, invalid-first
// allocation and duplicate suppression. Optional statistics counters under BTB_STATS_EN.
module btb_predictor #(
  parameter  int ENTRIES = 8,
  parameter  int PC_W    = 32,
  parameter  int CNT_W   = 2,
  localparam int POS_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             lookup_en,
  input  logic [PC_W-1:0]  pc_if,
  output logic             hit,
  output logic [POS_W-1:0] hit_pos,
  output logic [PC_W-1:0]  pred_pc,
  input  logic             upd_en,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_hit,
  input  logic [POS_W-1:0] upd_pos,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target,
  input  logic             upd_mispred
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]      stat_lookup,
  output logic [31:0]      stat_hit,
  output logic [31:0]      stat_mispred
`endif
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(1) << (CNT_W - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  logic             valid_q [ENTRIES];
  logic [CNT_W-1:0] cnt_q   [ENTRIES];
  logic [PC_W-1:0]  tag_q   [ENTRIES];
  logic [PC_W-1:0]  tgt_q   [ENTRIES];
  logic [POS_W-1:0] vptr_q, vptr_d;

  // IF stage: combinational lookup, never bypassed from a same-cycle update
  always_comb begin
    hit     = 1'b0;
    hit_pos = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == pc_if) begin
        hit     = 1'b1;
        hit_pos = POS_W'(i);
      end
    end
    pred_pc = pc_if + PC_W'(4);
    if (hit && cnt_q[hit_pos][CNT_W-1]) pred_pc = tgt_q[hit_pos];
  end

  logic             pos_ok;
  logic             srch_hit;
  logic [POS_W-1:0] srch_pos;
  logic             inv_found;
  logic [POS_W-1:0] inv_pos;
  logic             trn_en;
  logic [POS_W-1:0] trn_idx;
  logic             alc_en;
  logic [POS_W-1:0] alc_idx;

  // EX stage: pick the entry to train, falling back to a full search so a branch
  // allocated after it was fetched is trained rather than duplicated
  always_comb begin
    pos_ok    = upd_hit && valid_q[upd_pos] && (tag_q[upd_pos] == upd_pc);
    srch_hit  = 1'b0;
    srch_pos  = '0;
    inv_found = 1'b0;
    inv_pos   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == upd_pc) begin
        srch_hit = 1'b1;
        srch_pos = POS_W'(i);
      end
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        inv_found = 1'b1;
        inv_pos   = POS_W'(i);
      end
    end
    trn_en  = upd_en && (pos_ok || srch_hit);
    trn_idx = pos_ok ? upd_pos : srch_pos;
    alc_en  = upd_en && !pos_ok && !srch_hit && upd_taken;
    alc_idx = inv_found ? inv_pos : vptr_q;
    vptr_d  = vptr_q;
    if (alc_en && !inv_found) vptr_d = vptr_q + POS_W'(1);
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= '0;
      end
      vptr_q <= '0;
    end else begin
      if (trn_en) cnt_q[trn_idx] <= upd_taken ? sat_inc(cnt_q[trn_idx]) : sat_dec(cnt_q[trn_idx]);
      if (alc_en) begin
        valid_q[alc_idx] <= 1'b1;
        cnt_q[alc_idx]   <= CNT_INIT;
      end
      vptr_q <= vptr_d;
    end
  end

  // Tag/target storage is qualified by valid_q, so it needs no reset
  always_ff @(posedge clk) begin
    if (trn_en && upd_taken) tgt_q[trn_idx] <= upd_target;
    if (alc_en) begin
      tag_q[alc_idx] <= upd_pc;
      tgt_q[alc_idx] <= upd_target;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_lookup_q, stat_hit_q, stat_mispred_q;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      stat_lookup_q  <= '0;
      stat_hit_q     <= '0;
      stat_mispred_q <= '0;
    end else begin
      if (lookup_en)             stat_lookup_q  <= stat_lookup_q + 32'd1;
      if (lookup_en && hit)      stat_hit_q     <= stat_hit_q + 32'd1;
      if (upd_en && upd_mispred) stat_mispred_q <= stat_mispred_q + 32'd1;
    end
  end

  assign stat_lookup  = stat_lookup_q;
  assign stat_hit     = stat_hit_q;
  assign stat_mispred = stat_mispred_q;
`else
  logic unused_stat_inputs;
  assign unused_stat_inputs = lookup_en ^ upd_mispred;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed self-checking bench for btb_predictor (ENTRIES=8, PC_W=32, CNT_W=2).
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        RST;
  logic        lookup_en;
  logic [31:0] pc_if;
  logic        hit;
  logic [2:0]  hit_pos;
  logic [31:0] pred_pc;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_hit;
  logic [2:0]  upd_pos;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
`ifdef BTB_STATS_EN
  logic [31:0] stat_lookup, stat_hit, stat_mispred;
`endif

  int checks = 0;
  int errors = 0;

  btb_predictor #(.ENTRIES(8), .PC_W(32), .CNT_W(2)) dut (
    .clk(clk), .RST(RST), .lookup_en(lookup_en), .pc_if(pc_if),
    .hit(hit), .hit_pos(hit_pos), .pred_pc(pred_pc),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_hit(upd_hit), .upd_pos(upd_pos),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispred(upd_mispred)
`ifdef BTB_STATS_EN
    , .stat_lookup(stat_lookup), .stat_hit(stat_hit), .stat_mispred(stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  task automatic look(input logic [31:0] pc);
    pc_if = pc;
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic h, input logic [2:0] pos,
                     input logic tk, input logic [31:0] tgt);
    upd_en = 1'b1; upd_pc = pc; upd_hit = h; upd_pos = pos; upd_taken = tk; upd_target = tgt;
    @(posedge clk); #1;
    upd_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); RST = 1'b1;
    @(negedge clk); RST = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    look(32'h100);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %0b want 0", hit); end
    checks++; if (hit_pos !== 3'd0) begin errors++; $display("FAIL reset_pos got %0d want 0", hit_pos); end
    checks++; if (pred_pc !== 32'h104) begin errors++; $display("FAIL reset_pred got %h want 104", pred_pc); end
    @(negedge clk); RST = 1'b0; #1;
  endtask

  task automatic test_no_bypass();
    upd_en = 1'b1; upd_pc = 32'h100; upd_hit = 1'b0; upd_pos = 3'd0; upd_taken = 1'b1; upd_target = 32'h200;
    look(32'h100);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL nobypass_hit got %0b want 0", hit); end
    @(posedge clk); #1;
    upd_en = 1'b0;
  endtask

  task automatic test_alloc();
    look(32'h100);
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL alloc_hit got %0b want 1", hit); end
    checks++; if (hit_pos !== 3'd0) begin errors++; $display("FAIL alloc_pos got %0d want 0", hit_pos); end
    checks++; if (pred_pc !== 32'h200) begin errors++; $display("FAIL alloc_pred got %h want 200", pred_pc); end
  endtask

  task automatic test_counter();
    upd(32'h100, 1'b1, 3'd0, 1'b0, 32'h0);  // 10 -> 01
    look(32'h100);
    checks++; if (pred_pc !== 32'h104) begin errors++; $display("FAIL cnt01_pred got %h want 104", pred_pc); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL cnt01_hit got %0b want 1", hit); end
    upd(32'h100, 1'b1, 3'd0, 1'b0, 32'h0);  // 01 -> 00
    look(32'h100);
    checks++; if (pred_pc !== 32'h104) begin errors++; $display("FAIL cnt00_pred got %h want 104", pred_pc); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL cnt00_hit got %0b want 1", hit); end
    upd(32'h100, 1'b1, 3'd0, 1'b0, 32'h0);  // stays 00
    upd(32'h100, 1'b1, 3'd0, 1'b1, 32'h240); // 00 -> 01
    look(32'h100);
    checks++; if (pred_pc !== 32'h104) begin errors++; $display("FAIL cnt_floor_pred got %h want 104", pred_pc); end
    upd(32'h100, 1'b1, 3'd0, 1'b1, 32'h240); // 01 -> 10
    look(32'h100);
    checks++; if (pred_pc !== 32'h240) begin errors++; $display("FAIL cnt10_pred got %h want 240", pred_pc); end
    upd(32'h100, 1'b1, 3'd0, 1'b1, 32'h240); // 10 -> 11
    upd(32'h100, 1'b1, 3'd0, 1'b1, 32'h240); // saturates at 11
    upd(32'h100, 1'b1, 3'd0, 1'b0, 32'h0);   // 11 -> 10
    look(32'h100);
    checks++; if (pred_pc !== 32'h240) begin errors++; $display("FAIL cnt_sat_pred got %h want 240", pred_pc); end
    upd(32'h100, 1'b1, 3'd0, 1'b0, 32'h0);   // 10 -> 01
    look(32'h100);
    checks++; if (pred_pc !== 32'h104) begin errors++; $display("FAIL cnt_sat_dn_pred got %h want 104", pred_pc); end
  endtask

  task automatic test_stale_pos();
    // upd_pos points at an invalid entry: the search must find entry 0 (01 -> 10)
    upd(32'h100, 1'b1, 3'd5, 1'b1, 32'h280);
    look(32'h100);
    checks++; if (pred_pc !== 32'h280) begin errors++; $display("FAIL stale_pred got %h want 280", pred_pc); end
    upd(32'h180, 1'b0, 3'd0, 1'b1, 32'h380);
    look(32'h180);
    checks++; if (hit_pos !== 3'd1) begin errors++; $display("FAIL stale_nextpos got %0d want 1", hit_pos); end
    upd(32'h1C0, 1'b0, 3'd0, 1'b0, 32'h3C0);  // miss, not taken: no allocation
    look(32'h1C0);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL nt_noalloc_hit got %0b want 0", hit); end
  endtask

  task automatic test_replace();
    do_reset();
    for (int i = 0; i < 8; i++) upd(32'h1000 + 32'(i) * 32'h10, 1'b0, 3'd0, 1'b1, 32'h8000 + 32'(i) * 32'h10);
    for (int i = 0; i < 8; i++) begin
      look(32'h1000 + 32'(i) * 32'h10);
      checks++;
      if (hit !== 1'b1 || hit_pos !== 3'(i)) begin
        errors++; $display("FAIL fill_pos%0d got hit=%0b pos=%0d want hit=1 pos=%0d", i, hit, hit_pos, i);
      end
    end
    upd(32'h1080, 1'b0, 3'd0, 1'b1, 32'h8080);
    look(32'h1080);
    checks++; if (hit_pos !== 3'd0) begin errors++; $display("FAIL repl_pos got %0d want 0", hit_pos); end
    checks++; if (pred_pc !== 32'h8080) begin errors++; $display("FAIL repl_pred got %h want 8080", pred_pc); end
    look(32'h1000);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL repl_old_hit got %0b want 0", hit); end
    checks++; if (pred_pc !== 32'h1004) begin errors++; $display("FAIL repl_old_pred got %h want 1004", pred_pc); end
    upd(32'h10A0, 1'b0, 3'd0, 1'b1, 32'h80A0);  // vptr now 1
    look(32'h10A0);
    checks++; if (hit_pos !== 3'd1) begin errors++; $display("FAIL vptr_pos got %0d want 1", hit_pos); end
    look(32'h1010);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL vptr_old_hit got %0b want 0", hit); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    upd(32'h500, 1'b0, 3'd0, 1'b1, 32'h600);
    upd(32'h500, 1'b0, 3'd0, 1'b1, 32'h600);
    look(32'h500);
    checks++; if (hit !== 1'b1 || hit_pos !== 3'd0) begin errors++; $display("FAIL dedup_pos got hit=%0b pos=%0d want 1/0", hit, hit_pos); end
    upd(32'h500, 1'b1, 3'd0, 1'b0, 32'h0);  // 11 -> 10, still taken
    look(32'h500);
    checks++; if (pred_pc !== 32'h600) begin errors++; $display("FAIL dedup_cnt_pred got %h want 600", pred_pc); end
    upd(32'h700, 1'b0, 3'd0, 1'b1, 32'h800);
    look(32'h700);
    checks++; if (hit_pos !== 3'd1) begin errors++; $display("FAIL dedup_next_pos got %0d want 1", hit_pos); end
  endtask

  task automatic test_wrap();
    look(32'hFFFF_FFFC);
    checks++; if (pred_pc !== 32'h0) begin errors++; $display("FAIL wrap_pred got %h want 0", pred_pc); end
  endtask

  task automatic test_reset_discard();
    @(negedge clk);
    upd_en = 1'b1; upd_pc = 32'h900; upd_hit = 1'b0; upd_pos = 3'd0; upd_taken = 1'b1; upd_target = 32'hA00;
    RST = 1'b1;
    look(32'h500);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL async_clr_hit got %0b want 0", hit); end
    @(posedge clk); #1;
    upd_en = 1'b0;
    @(negedge clk); RST = 1'b0;
    look(32'h900);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rst_discard_hit got %0b want 0", hit); end
  endtask

`ifdef BTB_STATS_EN
  task automatic test_stats();
    do_reset();
    upd(32'h100, 1'b0, 3'd0, 1'b1, 32'h200);
    for (int i = 0; i < 10; i++) begin
      pc_if = (i < 4) ? 32'h100 : 32'h104;
      lookup_en = 1'b1;
      @(posedge clk); #1;
    end
    lookup_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      upd_mispred = 1'b1;
      upd(32'h9999_0000, 1'b0, 3'd0, 1'b0, 32'h0);
    end
    upd_mispred = 1'b0;
    checks++; if (stat_lookup !== 32'd10) begin errors++; $display("FAIL stat_lookup got %0d want 10", stat_lookup); end
    checks++; if (stat_hit !== 32'd4) begin errors++; $display("FAIL stat_hit got %0d want 4", stat_hit); end
    checks++; if (stat_mispred !== 32'd3) begin errors++; $display("FAIL stat_mispred got %0d want 3", stat_mispred); end
    do_reset();
    checks++; if ({stat_lookup, stat_hit, stat_mispred} !== 96'd0) begin
      errors++; $display("FAIL stat_clear got %0d/%0d/%0d want 0/0/0", stat_lookup, stat_hit, stat_mispred);
    end
  endtask
`endif

  initial begin
    RST = 1'b1; lookup_en = 1'b0; pc_if = '0;
    upd_en = 1'b0; upd_pc = '0; upd_hit = 1'b0; upd_pos = '0;
    upd_taken = 1'b0; upd_target = '0; upd_mispred = 1'b0;
    test_reset();
    test_no_bypass();
    test_alloc();
    test_counter();
    test_stale_pos();
    test_replace();
    test_back_to_back();
    test_wrap();
    test_reset_discard();
`ifdef BTB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
